// File: rtl/mmu_utlb.sv
// rtl/mmu_utlb.sv - per-port micro-TLB with a shared round-robin joint-TLB refill engine
module mmu_utlb #(
  parameter int NUM_PORTS  = 2,
  parameter int UTLB_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req_valid,
  input  logic [32*NUM_PORTS-1:0] req_vaddr,
  input  logic [NUM_PORTS-1:0]    req_write,
  input  logic                    user_mode,
  input  logic [7:0]              asid,
  input  logic                    flush,
  output logic [NUM_PORTS-1:0]    resp_valid,
  output logic [32*NUM_PORTS-1:0] resp_paddr,
  output logic [NUM_PORTS-1:0]    resp_uncached,
  output logic [NUM_PORTS-1:0]    exp_illegal,
  output logic [NUM_PORTS-1:0]    exp_miss,
  output logic [NUM_PORTS-1:0]    exp_invalid,
  output logic [NUM_PORTS-1:0]    exp_modified,
  output logic                    jtlb_req,
  output logic [19:0]             jtlb_vpn,
  output logic [7:0]              jtlb_asid,
  input  logic                    jtlb_ack,
  input  logic                    jtlb_hit,
  input  logic                    jtlb_valid,
  input  logic                    jtlb_dirty,
  input  logic                    jtlb_uncached,
  input  logic                    jtlb_global,
  input  logic [19:0]             jtlb_pfn
);
  localparam int PW = $clog2(UTLB_DEPTH);
  localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  // micro-TLB storage, one bank per port
  logic [UTLB_DEPTH-1:0] r_tv    [NUM_PORTS];
  logic [UTLB_DEPTH-1:0] r_tglb  [NUM_PORTS];
  logic [UTLB_DEPTH-1:0] r_tdirty[NUM_PORTS];
  logic [UTLB_DEPTH-1:0] r_tunc  [NUM_PORTS];
  logic [19:0]           r_tvpn  [NUM_PORTS][UTLB_DEPTH];
  logic [19:0]           r_tpfn  [NUM_PORTS][UTLB_DEPTH];
  logic [7:0]            r_tasid [NUM_PORTS][UTLB_DEPTH];
  logic [PW-1:0]         r_ptr   [NUM_PORTS];

  logic [1:0]            r_state;
  logic [SW-1:0]         r_sel;
  logic [SW-1:0]         r_rr;
  logic                  r_reissue;
  logic [NUM_PORTS-1:0]  r_pending;
  logic [19:0]           r_jvpn;
  logic [7:0]            r_jasid;
  logic                  r_f_hit, r_f_valid, r_f_dirty, r_f_unc, r_f_glb;
  logic [19:0]           r_f_pfn;

  logic [NUM_PORTS-1:0]    r_resp_valid, r_resp_unc, r_exp_ill, r_exp_miss, r_exp_inv, r_exp_mod;
  logic [32*NUM_PORTS-1:0] r_resp_paddr;

  logic [NUM_PORTS-1:0] w_accept, w_hit, w_hit_dirty, w_hit_unc;
  logic [19:0]          w_hit_pfn [NUM_PORTS];
  logic [SW-1:0]        w_sel;
  logic                 w_found;
  logic [19:0]          w_sel_vpn;
  logic [11:0]          w_cur_off;
  logic                 w_cur_write;

  // a request is new only when the port has nothing outstanding and is not being answered now
  assign w_accept = req_valid & ~r_pending & ~r_resp_valid;

  // outputs are forced quiet while reset is held
  assign resp_valid    = rst ? '0 : r_resp_valid;
  assign resp_paddr    = rst ? '0 : r_resp_paddr;
  assign resp_uncached = rst ? '0 : r_resp_unc;
  assign exp_illegal   = rst ? '0 : r_exp_ill;
  assign exp_miss      = rst ? '0 : r_exp_miss;
  assign exp_invalid   = rst ? '0 : r_exp_inv;
  assign exp_modified  = rst ? '0 : r_exp_mod;
  assign jtlb_req      = !rst && (r_state == S_REQ);
  assign jtlb_vpn      = r_jvpn;
  assign jtlb_asid     = r_jasid;

  // fully associative tag compare per port; global entries ignore the ASID
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_hit[p]       = 1'b0;
      w_hit_dirty[p] = 1'b0;
      w_hit_unc[p]   = 1'b0;
      w_hit_pfn[p]   = '0;
      for (int e = 0; e < UTLB_DEPTH; e++) begin
        if (r_tv[p][e] && (r_tvpn[p][e] == req_vaddr[32*p+12 +: 20]) &&
            (r_tglb[p][e] || (r_tasid[p][e] == asid))) begin
          w_hit[p]       = 1'b1;
          w_hit_dirty[p] = w_hit_dirty[p] | r_tdirty[p][e];
          w_hit_unc[p]   = w_hit_unc[p] | r_tunc[p][e];
          w_hit_pfn[p]   = w_hit_pfn[p] | r_tpfn[p][e];
        end
      end
    end
  end

  // round-robin pick of the next pending port, searching from r_rr
  always_comb begin
    w_sel   = r_rr;
    w_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_found && r_pending[(int'(r_rr) + i) % NUM_PORTS]) begin
        w_found = 1'b1;
        w_sel   = SW'((int'(r_rr) + i) % NUM_PORTS);
      end
    end
  end

  // mux out the address fields of the chosen and of the in-service port
  always_comb begin
    w_sel_vpn   = '0;
    w_cur_off   = '0;
    w_cur_write = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (SW'(p) == w_sel) w_sel_vpn = req_vaddr[32*p+12 +: 20];
      if (SW'(p) == r_sel) begin
        w_cur_off   = req_vaddr[32*p +: 12];
        w_cur_write = req_write[p];
      end
    end
  end

  // lookup responses, pending tracking, refill FSM and entry writes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sel        <= '0;
      r_rr         <= '0;
      r_reissue    <= 1'b0;
      r_pending    <= '0;
      r_jvpn       <= '0;
      r_jasid      <= '0;
      r_f_hit      <= 1'b0;
      r_f_valid    <= 1'b0;
      r_f_dirty    <= 1'b0;
      r_f_unc      <= 1'b0;
      r_f_glb      <= 1'b0;
      r_f_pfn      <= '0;
      r_resp_valid <= '0;
      r_resp_paddr <= '0;
      r_resp_unc   <= '0;
      r_exp_ill    <= '0;
      r_exp_miss   <= '0;
      r_exp_inv    <= '0;
      r_exp_mod    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_tv[p]  <= '0;
        r_ptr[p] <= '0;
      end
    end else begin
      r_resp_valid <= '0;
      r_resp_paddr <= '0;
      r_resp_unc   <= '0;
      r_exp_ill    <= '0;
      r_exp_miss   <= '0;
      r_exp_inv    <= '0;
      r_exp_mod    <= '0;

      if (flush) begin
        for (int p = 0; p < NUM_PORTS; p++) r_tv[p] <= '0;
      end

      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_accept[p]) begin
          if (user_mode && req_vaddr[32*p+31]) begin
            r_resp_valid[p] <= 1'b1;
            r_exp_ill[p]    <= 1'b1;
          end else if (req_vaddr[32*p+30 +: 2] == 2'b10) begin
            r_resp_valid[p]           <= 1'b1;
            r_resp_paddr[32*p +: 32]  <= {3'b000, req_vaddr[32*p +: 29]};
            r_resp_unc[p]             <= req_vaddr[32*p+29];
          end else if (w_hit[p] && !flush) begin
            r_resp_valid[p]           <= 1'b1;
            r_resp_paddr[32*p +: 32]  <= {w_hit_pfn[p], req_vaddr[32*p +: 12]};
            r_resp_unc[p]             <= w_hit_unc[p];
            r_exp_mod[p]              <= req_write[p] & ~w_hit_dirty[p];
          end else begin
            r_pending[p] <= 1'b1;
          end
        end
      end

      case (r_state)
        S_IDLE: begin
          if (r_reissue) begin
            r_reissue <= 1'b0;
            r_state   <= S_REQ;
          end else if (w_found) begin
            r_sel   <= w_sel;
            r_rr    <= (int'(w_sel) == NUM_PORTS - 1) ? '0 : w_sel + SW'(1);
            r_jvpn  <= w_sel_vpn;
            r_jasid <= asid;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) begin
            // joint TLB was rewritten: drop whatever comes back and ask again
            r_reissue <= 1'b1;
            r_state   <= S_IDLE;
          end else if (jtlb_ack) begin
            r_f_hit   <= jtlb_hit;
            r_f_valid <= jtlb_valid;
            r_f_dirty <= jtlb_dirty;
            r_f_unc   <= jtlb_uncached;
            r_f_glb   <= jtlb_global;
            r_f_pfn   <= jtlb_pfn;
            r_state   <= S_FILL;
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (SW'(p) == r_sel && !(jtlb_hit && jtlb_valid)) begin
                r_pending[p]    <= 1'b0;
                r_resp_valid[p] <= 1'b1;
                r_exp_miss[p]   <= !jtlb_hit;
                r_exp_inv[p]    <= jtlb_hit;
              end
            end
          end
        end
        S_FILL: begin
          r_state <= S_IDLE;
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (SW'(p) == r_sel && r_f_hit && r_f_valid) begin
              r_tv[p][r_ptr[p]]        <= !flush;
              r_tglb[p][r_ptr[p]]      <= r_f_glb;
              r_tdirty[p][r_ptr[p]]    <= r_f_dirty;
              r_tunc[p][r_ptr[p]]      <= r_f_unc;
              r_tvpn[p][r_ptr[p]]      <= r_jvpn;
              r_tpfn[p][r_ptr[p]]      <= r_f_pfn;
              r_tasid[p][r_ptr[p]]     <= r_jasid;
              r_ptr[p]                 <= r_ptr[p] + PW'(1);
              r_pending[p]             <= 1'b0;
              r_resp_valid[p]          <= 1'b1;
              r_resp_paddr[32*p +: 32] <= {r_f_pfn, w_cur_off};
              r_resp_unc[p]            <= r_f_unc;
              r_exp_mod[p]             <= w_cur_write & ~r_f_dirty;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmu_utlb.sv
// tb/tb_mmu_utlb.sv - directed self-checking bench for mmu_utlb
module tb_mmu_utlb;
  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_vaddr;
  logic [1:0]  req_write;
  logic        user_mode;
  logic [7:0]  asid;
  logic        flush;
  logic [1:0]  resp_valid;
  logic [63:0] resp_paddr;
  logic [1:0]  resp_uncached, exp_illegal, exp_miss, exp_invalid, exp_modified;
  logic        jtlb_req;
  logic [19:0] jtlb_vpn;
  logic [7:0]  jtlb_asid;
  logic        jtlb_ack, jtlb_hit, jtlb_valid, jtlb_dirty, jtlb_uncached, jtlb_global;
  logic [19:0] jtlb_pfn;

  int n_tests = 0;
  int n_fail  = 0;

  mmu_utlb #(.NUM_PORTS(2), .UTLB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_vaddr(req_vaddr), .req_write(req_write),
    .user_mode(user_mode), .asid(asid), .flush(flush),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_uncached(resp_uncached),
    .exp_illegal(exp_illegal), .exp_miss(exp_miss), .exp_invalid(exp_invalid),
    .exp_modified(exp_modified),
    .jtlb_req(jtlb_req), .jtlb_vpn(jtlb_vpn), .jtlb_asid(jtlb_asid),
    .jtlb_ack(jtlb_ack), .jtlb_hit(jtlb_hit), .jtlb_valid(jtlb_valid),
    .jtlb_dirty(jtlb_dirty), .jtlb_uncached(jtlb_uncached), .jtlb_global(jtlb_global),
    .jtlb_pfn(jtlb_pfn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic [31:0] va, input logic wr);
    req_valid[p]          = 1'b1;
    req_vaddr[32*p +: 32] = va;
    req_write[p]          = wr;
  endtask

  task automatic drop(input int p);
    req_valid[p] = 1'b0;
  endtask

  task automatic wait_jreq();
    int k;
    k = 0;
    while (jtlb_req !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    chk("jtlb_req_rise", {31'd0, jtlb_req}, 32'd1);
  endtask

  // waits for the refill request, checks it, acks after dly cycles; returns in the FILL cycle
  task automatic refill(input logic [19:0] vpn, input logic [7:0] as, input logic hit,
                        input logic valid, input logic dirty, input logic glb,
                        input logic [19:0] pfn, input int dly);
    wait_jreq();
    chk("jtlb_vpn", {12'd0, jtlb_vpn}, {12'd0, vpn});
    chk("jtlb_asid", {24'd0, jtlb_asid}, {24'd0, as});
    for (int i = 0; i < dly; i++) tick();
    chk("jtlb_req_held", {31'd0, jtlb_req}, 32'd1);
    jtlb_ack = 1'b1; jtlb_hit = hit; jtlb_valid = valid; jtlb_dirty = dirty;
    jtlb_global = glb; jtlb_uncached = 1'b0; jtlb_pfn = pfn;
    tick();
    jtlb_ack = 1'b0;
    chk("jtlb_req_fall", {31'd0, jtlb_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_vaddr = '0; req_write = '0; user_mode = 1'b0;
    asid = 8'h05; flush = 1'b0; jtlb_ack = 1'b0; jtlb_hit = 1'b0; jtlb_valid = 1'b0;
    jtlb_dirty = 1'b0; jtlb_uncached = 1'b0; jtlb_global = 1'b0; jtlb_pfn = '0;

    // reset: quiet during and after
    tick(); tick();
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("rst_jtlb_req", {31'd0, jtlb_req}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_valid", {30'd0, resp_valid}, 32'd0);
    chk("post_rst_jreq", {31'd0, jtlb_req}, 32'd0);
    chk("post_rst_paddr", resp_paddr[31:0] | resp_paddr[63:32], 32'd0);
    chk("post_rst_exp", {22'd0, exp_illegal, exp_miss, exp_invalid, exp_modified, resp_uncached}, 32'd0);

    // unmapped kseg0/kseg1 on both ports
    drive(0, 32'h8000_1234, 1'b0); drive(1, 32'hBFC0_0004, 1'b0);
    tick();
    chk("unmap_valid", {30'd0, resp_valid}, 32'd3);
    chk("kseg0_paddr", resp_paddr[31:0], 32'h0000_1234);
    chk("kseg1_paddr", resp_paddr[63:32], 32'h1FC0_0004);
    chk("unmap_unc", {30'd0, resp_uncached}, 32'd2);
    drop(0); drop(1); tick();
    drive(0, 32'hA000_0010, 1'b0);
    tick();
    chk("kseg1_valid", {31'd0, resp_valid[0]}, 32'd1);
    chk("kseg1_paddr0", resp_paddr[31:0], 32'h0000_0010);
    chk("kseg1_unc0", {31'd0, resp_uncached[0]}, 32'd1);
    drop(0); tick();

    // user access to kernel space
    user_mode = 1'b1;
    drive(0, 32'h9000_0000, 1'b0);
    tick();
    chk("ill_valid", {31'd0, resp_valid[0]}, 32'd1);
    chk("ill_flag", {31'd0, exp_illegal[0]}, 32'd1);
    chk("ill_paddr", resp_paddr[31:0], 32'd0);
    drop(0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin tick(); seen = seen | jtlb_req; end
      chk("ill_no_jreq", {31'd0, seen}, 32'd0);
    end
    user_mode = 1'b0;

    // simultaneous misses after reset: port0 then port1
    drive(0, 32'h0010_0000, 1'b0); drive(1, 32'h0020_0004, 1'b0);
    tick();
    chk("pairA_miss", {30'd0, resp_valid}, 32'd0);
    refill(20'h00100, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 20'h00AAA, 0);
    tick();
    chk("pairA_p0_valid", {30'd0, resp_valid}, 32'd1);
    chk("pairA_p0_paddr", resp_paddr[31:0], 32'h00AA_A000);
    drop(0);
    refill(20'h00200, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 20'h00BBB, 1);
    tick();
    chk("pairA_p1_valid", {30'd0, resp_valid}, 32'd2);
    chk("pairA_p1_paddr", resp_paddr[63:32], 32'h00BB_B004);
    drop(1); tick();

    // miss, refill after 3 cycles, then a one-cycle hit
    drive(0, 32'h0040_0ABC, 1'b0);
    tick();
    chk("m038_miss", {31'd0, resp_valid[0]}, 32'd0);
    refill(20'h00400, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 20'h12345, 3);
    chk("m038_fill_quiet", {31'd0, resp_valid[0]}, 32'd0);
    tick();
    chk("m038_valid", {31'd0, resp_valid[0]}, 32'd1);
    chk("m038_paddr", resp_paddr[31:0], 32'h1234_5ABC);
    chk("m038_flags", {28'd0, exp_miss[0], exp_invalid[0], exp_modified[0], resp_uncached[0]}, 32'd0);
    drop(0); tick();
    drive(0, 32'h0040_0ABC, 1'b0);
    tick();
    chk("hit_valid", {31'd0, resp_valid[0]}, 32'd1);
    chk("hit_paddr", resp_paddr[31:0], 32'h1234_5ABC);
    chk("hit_no_jreq", {31'd0, jtlb_req}, 32'd0);
    drop(0); tick();

    // next simultaneous miss: port1 first (port0 was served last); miss and invalid replies
    drive(0, 32'h0050_0000, 1'b0); drive(1, 32'h0060_0000, 1'b0);
    tick();
    refill(20'h00600, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 0);
    chk("jmiss_valid", {30'd0, resp_valid}, 32'd2);
    chk("jmiss_flag", {31'd0, exp_miss[1]}, 32'd1);
    drop(1);
    refill(20'h00500, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 20'h0, 0);
    chk("jinv_valid", {30'd0, resp_valid}, 32'd1);
    chk("jinv_flag", {31'd0, exp_invalid[0]}, 32'd1);
    drop(0); tick();

    // stores to a clean page, then ASID mismatch and a global entry
    drive(1, 32'h0070_0008, 1'b1);
    tick();
    refill(20'h00700, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00777, 0);
    tick();
    chk("mod_fill_flag", {31'd0, exp_modified[1]}, 32'd1);
    chk("mod_fill_paddr", resp_paddr[63:32], 32'h0077_7008);
    drop(1); tick();
    drive(1, 32'h0070_0008, 1'b1);
    tick();
    chk("mod_hit", {30'd0, resp_valid, exp_modified[1]}, 32'b101);
    drop(1); tick();
    drive(1, 32'h0070_0008, 1'b0);
    tick();
    chk("load_clean", {30'd0, resp_valid, exp_modified[1]}, 32'b100);
    drop(1); tick();
    asid = 8'h06;
    drive(1, 32'h0070_0008, 1'b0);
    tick();
    chk("asid_miss", {31'd0, resp_valid[1]}, 32'd0);
    refill(20'h00700, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 20'h00888, 0);
    tick();
    chk("glb_fill_paddr", resp_paddr[63:32], 32'h0088_8008);
    drop(1); tick();
    asid = 8'h07;
    drive(1, 32'h0070_0008, 1'b0);
    tick();
    chk("glb_hit_valid", {31'd0, resp_valid[1]}, 32'd1);
    chk("glb_hit_paddr", resp_paddr[63:32], 32'h0088_8008);
    drop(1); tick();
    asid = 8'h05;

    // five pages into four entries: the first is evicted
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h0000_1000 * (i + 1), 1'b0);
      tick();
      chk("evict_fill_miss", {31'd0, resp_valid[0]}, 32'd0);
      refill(20'(i + 1), 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 20'h20000 + 20'(i), i % 3);
      tick();
      chk("evict_fill_paddr", resp_paddr[31:0], {20'h20000 + 20'(i), 12'h000});
      drop(0); tick();
    end
    drive(0, 32'h0000_2000, 1'b0);
    tick();
    chk("evict_p1_hit", {31'd0, resp_valid[0]}, 32'd1);
    chk("evict_p1_paddr", resp_paddr[31:0], 32'h2000_1000);
    drop(0); tick();
    drive(0, 32'h0000_1000, 1'b0);
    tick();
    chk("evict_p0_miss", {31'd0, resp_valid[0]}, 32'd0);

    // flush while the request is out: reply discarded, request reissued
    wait_jreq();
    flush = 1'b1; jtlb_ack = 1'b1; jtlb_hit = 1'b1; jtlb_valid = 1'b1; jtlb_pfn = 20'h0DEAD;
    tick();
    flush = 1'b0; jtlb_ack = 1'b0;
    chk("flush_jreq_drop", {31'd0, jtlb_req}, 32'd0);
    chk("flush_no_resp", {31'd0, resp_valid[0]}, 32'd0);
    tick();
    chk("flush_jreq_again", {31'd0, jtlb_req}, 32'd1);
    refill(20'h00001, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 20'h30000, 1);
    tick();
    chk("reissue_paddr", resp_paddr[31:0], 32'h3000_0000);
    drop(0); tick();

    // lookup coinciding with flush misses; earlier entries are gone
    drive(0, 32'h0000_1000, 1'b0); flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_lookup_miss", {31'd0, resp_valid[0]}, 32'd0);
    refill(20'h00001, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 20'h31000, 0);
    tick();
    chk("flush_refill_paddr", resp_paddr[31:0], 32'h3100_0000);
    drop(0); tick();
    drive(0, 32'h0000_2000, 1'b0);
    tick();
    chk("flushed_p1_miss", {31'd0, resp_valid[0]}, 32'd0);
    refill(20'h00002, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 20'h20001, 0);
    tick();
    chk("flushed_p1_paddr", resp_paddr[31:0], 32'h2000_1000);
    drop(0); tick();

    // reset in the middle of a refill; the late ack is ignored
    drive(1, 32'h0090_0000, 1'b0);
    tick();
    wait_jreq();
    rst = 1'b1; req_valid = '0;
    tick();
    chk("midrst_jreq", {31'd0, jtlb_req}, 32'd0);
    rst = 1'b0;
    jtlb_ack = 1'b1; jtlb_hit = 1'b1; jtlb_valid = 1'b1; jtlb_pfn = 20'h0BEEF;
    tick();
    jtlb_ack = 1'b0;
    chk("late_ack_jreq", {31'd0, jtlb_req}, 32'd0);
    chk("late_ack_resp", {30'd0, resp_valid}, 32'd0);
    tick();
    chk("late_ack_jreq2", {31'd0, jtlb_req}, 32'd0);
    chk("late_ack_resp2", {30'd0, resp_valid}, 32'd0);
    drive(0, 32'h0000_2000, 1'b0);
    tick();
    chk("rst_cleared_miss", {31'd0, resp_valid[0]}, 32'd0);
    refill(20'h00002, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0, 20'h40000, 0);
    tick();
    chk("rst_refill_paddr", resp_paddr[31:0], 32'h4000_0000);
    drop(0); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mmu_utlb.md
MMU_UTLB -- requirements
Module: mmu_utlb

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of independent translation ports (1..4).
REQ-002 Parameter UTLB_DEPTH, default 4, micro-TLB entries per port, power of two (2..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  NUM_PORTS  per-port translation request, held high until that port's resp_valid.
REQ-006 req_vaddr  input  32*NUM_PORTS  per-port virtual address, port p at [32p+31:32p].
REQ-007 req_write  input  NUM_PORTS  per-port store flag.
REQ-008 user_mode  input  1  from cp0; 1 = user mode.
REQ-009 asid  input  8  current ASID from cp0.
REQ-010 flush  input  1  one-cycle pulse on TLBWI; invalidates all micro-TLB entries.
REQ-011 resp_valid  output  NUM_PORTS  one-cycle response strobe per port.
REQ-012 resp_paddr  output  32*NUM_PORTS  physical address, valid with resp_valid.
REQ-013 resp_uncached, exp_illegal, exp_miss, exp_invalid, exp_modified  output  NUM_PORTS each  per-port attribute/exception flags, valid with resp_valid.
REQ-014 jtlb_req  output  1  refill request to joint TLB; jtlb_vpn output 20 (vaddr[31:12]); jtlb_asid output 8.
REQ-015 jtlb_ack  input  1  refill done; jtlb_hit, jtlb_valid, jtlb_dirty, jtlb_uncached, jtlb_global input 1 each; jtlb_pfn input 20; all sampled only when jtlb_ack=1.

Function
REQ-016 Decode: kuseg (va[31]=0) and kseg2/3 (va[31:30]=11) mapped; kseg0 (100) unmapped cached; kseg1 (101) unmapped uncached.
REQ-017 Unmapped paddr = {3'b000, va[28:0]}; resp_uncached=1 only for kseg1.
REQ-018 user_mode=1 with va[31]=1: exp_illegal=1, resp_paddr=0, no lookup, no refill.
REQ-019 Unmapped/illegal and micro-TLB hits respond exactly 1 cycle after req_valid first seen high (registered outputs).
REQ-020 Entry: valid, vpn[19:0], asid[7:0], global, pfn[19:0], dirty, uncached; hit = valid && vpn==va[31:12] && (global || asid match); paddr = {pfn, va[11:0]}.
REQ-021 Hit with req_write=1 and dirty=0: exp_modified=1; otherwise flags 0 except resp_uncached from entry.
REQ-022 Miss marks port pending; refill engine serves one pending port at a time, round-robin starting after the last-served port.
REQ-023 Refill FSM: IDLE -> REQ (jtlb_req=1, vpn/asid of selected port, held stable) -> on jtlb_ack -> FILL -> IDLE.
REQ-024 jtlb_req stays high until the jtlb_ack cycle; falls the cycle after; no new request in the FILL cycle.
REQ-025 ack, hit=1, valid=1: in FILL, write entry at port's replacement pointer, pointer increments mod UTLB_DEPTH; response in the cycle after FILL with hit semantics (REQ-020/021).
REQ-026 ack, hit=0: exp_miss=1 response in FILL cycle, no write. hit=1, valid=0: exp_invalid=1 response in FILL cycle, no write.
REQ-027 Entry asid field written from jtlb_asid; global copied from jtlb_global.
REQ-028 flush clears all valid bits next cycle; lookup coinciding with flush is a miss.
REQ-029 flush while FSM in REQ: returned data discarded, FSM reissues same port's request (jtlb_req drops for 1 cycle then rises).
REQ-030 Replacement pointers not reset by flush; wrap from UTLB_DEPTH-1 to 0.
REQ-031 Port dropping req_valid before response (illegal) need not be handled; behaviour undefined.
REQ-032 ASID change needs no flush; tag compare handles it.

Reset
REQ-033 rst=1: all entries invalid, pointers 0, round-robin pointer 0, FSM IDLE, pending bits 0.
REQ-034 During and cycle after rst: resp_valid, jtlb_req, all exp_* flags 0, resp_paddr 0.
REQ-035 rst mid-refill: jtlb_req low next cycle; late jtlb_ack ignored.

Verification
REQ-036 Port0 va=0x8000_1234, kernel -> 1 cycle later resp_paddr=0x0000_1234, uncached=0; va=0xA000_0010 -> 0x0000_0010, uncached=1.
REQ-037 user_mode=1, va=0x9000_0000 -> exp_illegal=1, jtlb_req never asserts.
REQ-038 va=0x0040_0ABC miss, ack after 3 cycles with hit=1,valid=1,pfn=0x12345 -> resp_paddr=0x1234_5ABC; repeat -> 1-cycle hit, no jtlb_req.
REQ-039 Both ports miss same cycle -> port0 served first, then port1; next simultaneous miss serves port1 first.
REQ-040 Ack hit=0 -> exp_miss=1 in FILL cycle; ack hit=1,valid=0 -> exp_invalid=1; store to dirty=0 page -> exp_modified=1.
REQ-041 Fill UTLB_DEPTH+1 distinct pages on port0 -> first page evicted and misses; flush during REQ -> request reissued, stale data not written.
